// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM and the datapath mux encodings.
package mc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] REG_SRC_ALU  = 2'd0;
  localparam logic [1:0] REG_SRC_MEM  = 2'd1;
  localparam logic [1:0] REG_SRC_PC4  = 2'd2;
  localparam logic [1:0] REG_SRC_IMM  = 2'd3;

  localparam logic [1:0] ALU_A_PC     = 2'd0;
  localparam logic [1:0] ALU_A_OLDPC  = 2'd1;
  localparam logic [1:0] ALU_A_RS1    = 2'd2;
  localparam logic [1:0] ALU_A_ZERO   = 2'd3;

  localparam logic [1:0] ALU_B_RS2    = 2'd0;
  localparam logic [1:0] ALU_B_IMM    = 2'd1;
  localparam logic [1:0] ALU_B_FOUR   = 2'd2;

  localparam logic [1:0] ALU_ADD      = 2'd0;
  localparam logic [1:0] ALU_FUNC     = 2'd1;
  localparam logic [1:0] ALU_BR       = 2'd2;
  localparam logic [1:0] ALU_PASS_B   = 2'd3;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_RESULT = 1'b1;
  localparam logic ADDR_PC       = 1'b0;
  localparam logic ADDR_RESULT   = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  // Per-state control word; *_ack fields are qualified by a good memory handshake,
  // pc_upd_br by the branch condition.
  typedef struct packed {
    logic       pc_upd;
    logic       pc_upd_ack;
    logic       pc_upd_br;
    logic       pc_src;
    logic       ir_wr_ack;
    logic       addr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
    logic       trap;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;  c.addr_src = ADDR_PC;
        c.alu_src_a = ALU_A_PC; c.alu_src_b = ALU_B_FOUR; c.alu_ctrl = ALU_ADD;
        c.ir_wr_ack = 1'b1; c.pc_upd_ack = 1'b1; c.pc_src = PC_SRC_ALU;
      end
      S_DECODE:   begin c.alu_src_a = ALU_A_OLDPC; c.alu_src_b = ALU_B_IMM; c.alu_ctrl = ALU_ADD; end
      S_EXEC_R:   begin c.alu_src_a = ALU_A_RS1; c.alu_src_b = ALU_B_RS2; c.alu_ctrl = ALU_FUNC; end
      S_EXEC_I:   begin c.alu_src_a = ALU_A_RS1; c.alu_src_b = ALU_B_IMM; c.alu_ctrl = ALU_FUNC; end
      S_ALU_WB:   begin c.reg_write = 1'b1; c.reg_src = REG_SRC_ALU; end
      S_MEM_ADDR: begin c.alu_src_a = ALU_A_RS1; c.alu_src_b = ALU_B_IMM; c.alu_ctrl = ALU_ADD; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.addr_src = ADDR_RESULT; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.reg_src = REG_SRC_MEM; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.addr_src = ADDR_RESULT; end
      S_BRANCH: begin
        c.alu_src_a = ALU_A_RS1; c.alu_src_b = ALU_B_RS2; c.alu_ctrl = ALU_BR;
        c.pc_upd_br = 1'b1; c.pc_src = PC_SRC_RESULT;
      end
      S_JAL: begin
        c.reg_write = 1'b1; c.reg_src = REG_SRC_PC4; c.pc_upd = 1'b1; c.pc_src = PC_SRC_RESULT;
      end
      S_JALR: begin
        c.alu_src_a = ALU_A_RS1; c.alu_src_b = ALU_B_IMM; c.alu_ctrl = ALU_ADD;
        c.reg_write = 1'b1; c.reg_src = REG_SRC_PC4; c.pc_upd = 1'b1; c.pc_src = PC_SRC_ALU;
      end
      S_LUI:   begin c.reg_write = 1'b1; c.reg_src = REG_SRC_IMM; end
      S_AUIPC: begin
        c.alu_src_a = ALU_A_OLDPC; c.alu_src_b = ALU_B_IMM; c.reg_write = 1'b1; c.reg_src = REG_SRC_ALU;
      end
      S_TRAP:  c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles in a waiting state and flags the last allowed one.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  input  logic mem_ready,
  output logic timeout_c
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          stall_c;

  assign stall_c   = in_wait & ~mem_ready;
  assign timeout_c = stall_c & (cnt_q == LAST);

  // Any cycle that is not a continuing stall leaves the counter at zero for the next wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_c && !timeout_c) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the OTTER RV32I core with memory handshake, timeout and trap.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          TRAP_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  input  logic             mem_error,
  output logic             pcUpdate,
  output logic             pcSrc,
  output logic             irWrite,
  output logic             addrSrc,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic [1:0]       regSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluCtrl,
  output logic             trap,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic             done_c, ack_c, in_wait_c, timeout_c;
  logic [CNT_W-1:0] instret_q;

  assign in_wait_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign ack_c     = mem_ready & ~mem_error;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_wait   (in_wait_c),
    .mem_ready (mem_ready),
    .timeout_c (timeout_c)
  );

  // Next state and instruction-completion strobe.
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (timeout_c) begin
          state_d = S_TRAP;
        end else if (mem_ready) begin
          if (mem_error) begin
            state_d = S_TRAP;
          end else begin
            case (state_q)
              S_FETCH:  state_d = S_DECODE;
              S_MEM_RD: state_d = S_MEM_WB;
              default: begin
                state_d = S_FETCH;
                done_c  = 1'b1;
              end
            endcase
          end
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_IMM:             state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          default: begin
            if (TRAP_ILLEGAL) begin
              state_d = S_TRAP;
            end else begin
              state_d = S_FETCH;
              done_c  = 1'b1;
            end
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR:         state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC: begin
        state_d = S_FETCH;
        done_c  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Control word is registered from the next state so it always matches state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (done_c) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign pcUpdate = ctrl_q.pc_upd | (ctrl_q.pc_upd_ack & ack_c) | (ctrl_q.pc_upd_br & br_taken);
  assign pcSrc    = ctrl_q.pc_src;
  assign irWrite  = ctrl_q.ir_wr_ack & ack_c;
  assign addrSrc  = ctrl_q.addr_src;
  assign memRead  = ctrl_q.mem_read;
  assign memWrite = ctrl_q.mem_write;
  assign regWrite = ctrl_q.reg_write;
  assign regSrc   = ctrl_q.reg_src;
  assign aluSrcA  = ctrl_q.alu_src_a;
  assign aluSrcB  = ctrl_q.alu_src_b;
  assign aluCtrl  = ctrl_q.alu_ctrl;
  assign trap     = ctrl_q.trap;
  assign retire   = done_c;
  assign instret  = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control vectors queued by the driver.
module tb_mc_control_fsm;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = OP_R;
  logic br_taken = 1'b0, mem_ready = 1'b0, mem_error = 1'b0;

  logic pcUpdate, pcSrc, irWrite, addrSrc, memRead, memWrite, regWrite, trap, retire;
  logic [1:0] regSrc, aluSrcA, aluSrcB, aluCtrl;
  logic [31:0] instret;

  logic n_pcUpdate, n_pcSrc, n_irWrite, n_addrSrc, n_memRead, n_memWrite, n_regWrite, n_trap, n_retire;
  logic [1:0] n_regSrc, n_aluSrcA, n_aluSrcB, n_aluCtrl;
  logic [3:0] n_instret;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(4), .TRAP_ILLEGAL(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_error(mem_error),
    .pcUpdate(pcUpdate), .pcSrc(pcSrc), .irWrite(irWrite), .addrSrc(addrSrc),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .regSrc(regSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluCtrl(aluCtrl), .trap(trap),
    .retire(retire), .instret(instret)
  );

  mc_control_fsm #(.MEM_TIMEOUT(16), .TRAP_ILLEGAL(1'b0), .CNT_W(4)) u_nop (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_error(mem_error),
    .pcUpdate(n_pcUpdate), .pcSrc(n_pcSrc), .irWrite(n_irWrite), .addrSrc(n_addrSrc),
    .memRead(n_memRead), .memWrite(n_memWrite), .regWrite(n_regWrite), .regSrc(n_regSrc),
    .aluSrcA(n_aluSrcA), .aluSrcB(n_aluSrcB), .aluCtrl(n_aluCtrl), .trap(n_trap),
    .retire(n_retire), .instret(n_instret)
  );

  logic [16:0] obs;
  assign obs = {pcUpdate, pcSrc, irWrite, addrSrc, memRead, memWrite, regWrite,
                regSrc, aluSrcA, aluSrcB, aluCtrl, trap, retire};

  typedef struct {
    string       tag;
    logic [16:0] vec;
    logic [31:0] cnt;
    bit          chk_nop;
    logic        nop_ret;
    logic [3:0]  nop_cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;
  logic [3:0]  exp_nop = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected control vector, fields in the order of obs.
  function automatic logic [16:0] v(input int pcu, pcs, irw, adr, mrd, mwr, rw,
                                    input int rs, a, b, c, tr, ret);
    return {1'(pcu), 1'(pcs), 1'(irw), 1'(adr), 1'(mrd), 1'(mwr), 1'(rw),
            2'(rs), 2'(a), 2'(b), 2'(c), 1'(tr), 1'(ret)};
  endfunction

  logic [16:0] V_FW, V_FR, V_DEC, V_MADDR, V_TRAP;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check({e_mon.tag, "/out"}, 32'(obs), 32'(e_mon.vec));
      check({e_mon.tag, "/instret"}, instret, e_mon.cnt);
      if (e_mon.chk_nop) begin
        check({e_mon.tag, "/nop_retire"}, 32'(n_retire), 32'(e_mon.nop_ret));
        check({e_mon.tag, "/nop_instret"}, 32'(n_instret), 32'(e_mon.nop_cnt));
      end
    end
  end

  task automatic do_cycle(input int rdy, err, br, input logic [16:0] vec, input string tag,
                          input bit chk_nop = 1'b0, input logic nop_ret = 1'b0);
    exp_t e;
    mem_ready = 1'(rdy);
    mem_error = 1'(err);
    br_taken  = 1'(br);
    e.tag = tag; e.vec = vec; e.cnt = exp_cnt;
    e.chk_nop = chk_nop; e.nop_ret = nop_ret; e.nop_cnt = exp_nop;
    exp_q.push_back(e);
    if (vec[0]) exp_cnt = exp_cnt + 32'd1;
    if (chk_nop && nop_ret) exp_nop = exp_nop + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) do_cycle(0, 0, 0, V_FW, "fetch_wait");
    do_cycle(1, 0, 0, V_FR, "fetch");
  endtask

  // Reset with a stale memory response pending; it must be ignored in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(obs), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_nop_instret", 32'(n_instret), 32'd0);
    rst_n = 1'b1;
    exp_cnt = '0;
    exp_nop = '0;
    do_cycle(1, 0, 0, 17'd0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    V_FW    = v(0,0,0,0,1,0,0, 0,0,2,0, 0,0);
    V_FR    = v(1,0,1,0,1,0,0, 0,0,2,0, 0,0);
    V_DEC   = v(0,0,0,0,0,0,0, 0,1,1,0, 0,0);
    V_MADDR = v(0,0,0,0,0,0,0, 0,2,1,0, 0,0);
    V_TRAP  = v(0,0,0,0,0,0,0, 0,0,0,0, 1,0);

    do_reset();

    // ADD with memory always ready: retires in cycle 4
    opcode = OP_R; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "add_dec");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,0, 0,2,0,1, 0,0), "add_exec");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,1, 0,0,0,0, 0,1), "add_wb");

    // LW, ready on the 4th cycle of each access (equal to the timeout limit)
    opcode = OP_LOAD; fetch(3);
    do_cycle(1, 0, 0, V_DEC, "lw_dec");
    do_cycle(1, 0, 0, V_MADDR, "lw_addr");
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, v(0,0,0,1,1,0,0, 0,0,0,0, 0,0), "lw_rd_wait");
    do_cycle(1, 0, 0, v(0,0,0,1,1,0,0, 0,0,0,0, 0,0), "lw_rd");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,1, 1,0,0,0, 0,1), "lw_wb");

    // BEQ not taken, then taken
    opcode = OP_BRANCH;
    for (int t = 0; t < 2; t++) begin
      fetch(0);
      do_cycle(1, 0, 0, V_DEC, "beq_dec");
      do_cycle(1, 0, t, v(t,1,0,0,0,0,0, 0,2,0,2, 0,1), t == 0 ? "beq_nt" : "beq_t");
    end

    opcode = OP_IMM; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "addi_dec");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,0, 0,2,1,1, 0,0), "addi_exec");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,1, 0,0,0,0, 0,1), "addi_wb");

    opcode = OP_STORE; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "sw_dec");
    do_cycle(1, 0, 0, V_MADDR, "sw_addr");
    do_cycle(0, 0, 0, v(0,0,0,1,0,1,0, 0,0,0,0, 0,0), "sw_wait");
    do_cycle(1, 0, 0, v(0,0,0,1,0,1,0, 0,0,0,0, 0,1), "sw_done");

    opcode = OP_JAL; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "jal_dec");
    do_cycle(1, 0, 0, v(1,1,0,0,0,0,1, 2,0,0,0, 0,1), "jal");
    opcode = OP_JALR; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "jalr_dec");
    do_cycle(1, 0, 0, v(1,0,0,0,0,0,1, 2,2,1,0, 0,1), "jalr");
    opcode = OP_LUI; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "lui_dec");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,1, 3,0,0,0, 0,1), "lui");
    opcode = OP_AUIPC; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "auipc_dec");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,1, 0,1,1,0, 0,1), "auipc");

    // Async reset while a store waits on memory
    opcode = OP_STORE; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "sw2_dec");
    do_cycle(1, 0, 0, V_MADDR, "sw2_addr");
    do_cycle(0, 0, 0, v(0,0,0,1,0,1,0, 0,0,0,0, 0,0), "sw2_wait");
    check("sw2_memwrite_held", 32'(memWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_memwrite", 32'(memWrite), 32'd0);
    check("async_rst_out", 32'(obs), 32'd0);
    check("async_rst_instret", instret, 32'd0);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = '0;
    exp_nop = '0;
    do_cycle(1, 0, 0, 17'd0, "idle_after_rst");
    opcode = OP_LUI; fetch(0);
    do_cycle(1, 0, 0, V_DEC, "lui2_dec");
    do_cycle(1, 0, 0, v(0,0,0,0,0,0,1, 3,0,0,0, 0,1), "lui2");

    // Fetch timeout: no ready for 4 cycles, trap is sticky
    do_reset();
    opcode = OP_R;
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, V_FW, "to_wait");
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 1, V_TRAP, "to_trap");
    do_cycle(1, 1, 0, V_TRAP, "to_trap_err");

    // Access fault on fetch: writes suppressed, then trap
    do_reset();
    do_cycle(1, 1, 0, V_FW, "fetch_err");
    do_cycle(1, 0, 0, V_TRAP, "err_trap");

    // Illegal opcode: trap on u_dut, NOP retire on u_nop with 4-bit counter wrap
    do_reset();
    opcode = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      do_cycle(1, 0, 0, i == 0 ? V_FR : V_TRAP, "ill_fetch", 1'b1, 1'b0);
      do_cycle(1, 0, 0, i == 0 ? V_DEC : V_TRAP, "ill_dec", 1'b1, 1'b1);
    end
    do_cycle(1, 0, 0, V_TRAP, "ill_wrap", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
